// File: rtl/ex_mem_skid_stage_pkg.sv
// Shared definitions for the EX->MEM pipeline stage: control-bit positions,
// payload width helper and the occupancy state encoding.
package ex_mem_skid_stage_pkg;

    localparam int unsigned CTRL_REGWRITE = 0;
    localparam int unsigned CTRL_MEMTOREG = 1;
    localparam int unsigned CTRL_MEMWRITE = 2;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    function automatic int unsigned payload_w(input int unsigned ctrl_w,
                                              input int unsigned data_w,
                                              input int unsigned reg_w);
        return ctrl_w + 2 * data_w + reg_w;
    endfunction

endpackage

// File: rtl/pipe_payload_reg.sv
// Width-parametrised payload register with synchronous clear (priority) and load enable.
module pipe_payload_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (clr_i) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/ex_mem_skid_stage.sv
// EX->MEM pipeline register with valid/ready handshake, optional one-entry skid buffer,
// synchronous flush and bubble insertion (out_ctrl forced to zero when invalid).
module ex_mem_skid_stage
    import ex_mem_skid_stage_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned REG_W   = 5,
    parameter int unsigned CTRL_W  = 3,
    parameter int unsigned SKID_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [REG_W-1:0]  in_wreg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_wdata,
    output logic [REG_W-1:0]  out_wreg,
    output logic [1:0]        occupancy
);

    localparam int unsigned PayloadW = payload_w(CTRL_W, DATA_W, REG_W);

    state_e              state_q, state_d;
    logic                accept, fire;
    logic                main_en, skid_en, clr;
    logic [PayloadW-1:0] in_payload, main_d, main_q, skid_payload;
    logic [CTRL_W-1:0]   main_ctrl;

    assign accept     = in_valid & in_ready;
    assign fire       = out_valid & out_ready;
    assign clr        = rst | flush;
    assign in_payload = {in_ctrl, in_alu, in_wdata, in_wreg};
    assign out_valid  = (state_q != StEmpty);
    assign occupancy  = state_q;

    always_comb begin
        state_d = state_q;
        main_en = 1'b0;
        skid_en = 1'b0;
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d = StOne;
                    main_en = 1'b1;
                end
            end
            StOne: begin
                if (accept && fire) begin
                    main_en = 1'b1;
                end else if (accept) begin
                    state_d = StTwo;
                    skid_en = 1'b1;
                end else if (fire) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (fire) begin
                    state_d = StOne;
                    main_en = 1'b1;
                end
            end
            default: state_d = StEmpty;
        endcase
        if (flush) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Draining from TWO refills the main entry from the skid entry.
    assign main_d = (state_q == StTwo) ? skid_payload : in_payload;

    pipe_payload_reg #(
        .WIDTH(PayloadW)
    ) u_main (
        .clk  (clk),
        .clr_i(clr),
        .en_i (main_en),
        .d_i  (main_d),
        .q_o  (main_q)
    );

    if (SKID_EN != 0) begin : g_skid
        assign in_ready = (state_q != StTwo);

        pipe_payload_reg #(
            .WIDTH(PayloadW)
        ) u_skid (
            .clk  (clk),
            .clr_i(clr),
            .en_i (skid_en),
            .d_i  (in_payload),
            .q_o  (skid_payload)
        );
    end else begin : g_no_skid
        assign in_ready     = !out_valid || out_ready;
        assign skid_payload = '0;
    end

    assign {main_ctrl, out_alu, out_wdata, out_wreg} = main_q;
    assign out_ctrl = main_ctrl & {CTRL_W{out_valid}};

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Bench for ex_mem_skid_stage: skid and no-skid instances share stimulus and are
// checked against queue-based models of a 2-entry and a 1-entry FIFO stage.
module tb_ex_mem_skid_stage;

    typedef struct packed {
        logic [2:0]  c;
        logic [31:0] a;
        logic [31:0] w;
        logic [4:0]  r;
    } pl_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [2:0]  in_ctrl;
    logic [31:0] in_alu, in_wdata;
    logic [4:0]  in_wreg;

    logic        rdy0, vld0, rdy1, vld1;
    logic [2:0]  ctl0, ctl1;
    logic [31:0] alu0, wd0, alu1, wd1;
    logic [4:0]  wr0, wr1;
    logic [1:0]  occ0, occ1;

    int n_chk = 0;
    int n_err = 0;
    pl_t q0[$];
    pl_t q1[$];

    always #5 clk = ~clk;

    ex_mem_skid_stage #(.DATA_W(32), .REG_W(5), .CTRL_W(3), .SKID_EN(1)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
        .in_ctrl(in_ctrl), .in_alu(in_alu), .in_wdata(in_wdata), .in_wreg(in_wreg),
        .out_valid(vld0), .out_ready(out_ready), .out_ctrl(ctl0), .out_alu(alu0),
        .out_wdata(wd0), .out_wreg(wr0), .occupancy(occ0)
    );

    ex_mem_skid_stage #(.DATA_W(32), .REG_W(5), .CTRL_W(3), .SKID_EN(0)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
        .in_ctrl(in_ctrl), .in_alu(in_alu), .in_wdata(in_wdata), .in_wreg(in_wreg),
        .out_valid(vld1), .out_ready(out_ready), .out_ctrl(ctl1), .out_alu(alu1),
        .out_wdata(wd1), .out_wreg(wr1), .occupancy(occ1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, check outputs against the models, then advance the models.
    task automatic step(input logic r, input logic f, input logic iv, input pl_t p,
                        input logic ordy);
        logic e_rdy0, e_rdy1, acc0, acc1, fire0, fire1;
        rst = r; flush = f; in_valid = iv; out_ready = ordy;
        {in_ctrl, in_alu, in_wdata, in_wreg} = p;
        #1;
        e_rdy0 = (q0.size() < 2);
        e_rdy1 = (q1.size() == 0) || ordy;
        chk("skid.in_ready", 64'(rdy0), 64'(e_rdy0));
        chk("skid.out_valid", 64'(vld0), 64'(q0.size() > 0));
        chk("skid.occupancy", 64'(occ0), 64'(q0.size()));
        chk("skid.out_ctrl", 64'(ctl0), (q0.size() > 0) ? 64'(q0[0].c) : 64'd0);
        if (q0.size() > 0) begin
            chk("skid.out_alu", 64'(alu0), 64'(q0[0].a));
            chk("skid.out_wdata", 64'(wd0), 64'(q0[0].w));
            chk("skid.out_wreg", 64'(wr0), 64'(q0[0].r));
        end
        chk("noskid.in_ready", 64'(rdy1), 64'(e_rdy1));
        chk("noskid.out_valid", 64'(vld1), 64'(q1.size() > 0));
        chk("noskid.occupancy", 64'(occ1), 64'(q1.size()));
        chk("noskid.out_ctrl", 64'(ctl1), (q1.size() > 0) ? 64'(q1[0].c) : 64'd0);
        if (q1.size() > 0) begin
            chk("noskid.out_alu", 64'(alu1), 64'(q1[0].a));
            chk("noskid.out_wdata", 64'(wd1), 64'(q1[0].w));
            chk("noskid.out_wreg", 64'(wr1), 64'(q1[0].r));
        end
        acc0  = iv && e_rdy0;
        acc1  = iv && e_rdy1;
        fire0 = (q0.size() > 0) && ordy;
        fire1 = (q1.size() > 0) && ordy;
        @(posedge clk);
        if (r || f) begin
            q0.delete();
            q1.delete();
        end else begin
            if (fire0) void'(q0.pop_front());
            if (acc0) q0.push_back(p);
            if (fire1) void'(q1.pop_front());
            if (acc1) q1.push_back(p);
        end
        #1;
    endtask

    task automatic chk_reset_fields();
        chk("rst.skid.out_alu", 64'(alu0), 64'd0);
        chk("rst.skid.out_wdata", 64'(wd0), 64'd0);
        chk("rst.skid.out_wreg", 64'(wr0), 64'd0);
        chk("rst.noskid.out_alu", 64'(alu1), 64'd0);
        chk("rst.noskid.out_wdata", 64'(wd1), 64'd0);
        chk("rst.noskid.out_wreg", 64'(wr1), 64'd0);
    endtask

    initial begin
        pl_t idle, pa, pb, pc, pdead, p;
        idle  = '0;
        pa    = '{c: 3'b101, a: 32'h1, w: 32'hAAAA_0001, r: 5'd3};
        pb    = '{c: 3'b011, a: 32'h2, w: 32'hBBBB_0002, r: 5'd4};
        pc    = '{c: 3'b001, a: 32'h3, w: 32'hCCCC_0003, r: 5'd7};
        pdead = '{c: 3'b111, a: 32'hDEAD, w: 32'hDEAD_DEAD, r: 5'd31};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_alu = '0; in_wdata = '0; in_wreg = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_fields();

        // Single pass
        step(0, 0, 1, '{c: 3'b001, a: 32'h0000_00A5, w: 32'h1234_5678, r: 5'd9}, 1);
        step(0, 0, 0, idle, 1);
        step(0, 0, 0, idle, 1);

        // Back-pressure: skid fills to two, then drains in order
        step(0, 0, 1, pa, 0);
        step(0, 0, 1, pb, 0);
        step(0, 0, 0, idle, 0);
        step(0, 0, 0, idle, 1);
        step(0, 0, 0, idle, 1);
        step(0, 0, 0, idle, 1);

        // Streaming
        for (int i = 0; i < 8; i++) begin
            p = '{c: 3'(i), a: 32'(i), w: 32'(i * 3), r: 5'(i)};
            step(0, 0, 1, p, 1);
        end
        step(0, 0, 0, idle, 1);
        step(0, 0, 0, idle, 1);

        // Flush while full; 0xDEAD presented in the flush cycle is dropped
        step(0, 0, 1, pa, 0);
        step(0, 0, 1, pb, 0);
        step(0, 1, 1, pdead, 0);
        step(0, 0, 0, idle, 0);
        step(0, 0, 0, idle, 1);

        // Combinational ready on the no-skid instance
        step(0, 0, 1, pa, 0);
        step(0, 0, 0, idle, 0);
        step(0, 0, 1, pc, 1);
        step(0, 0, 0, idle, 0);
        step(0, 0, 0, idle, 1);
        step(0, 0, 0, idle, 1);

        // Reset mid-stall
        step(0, 0, 1, pa, 0);
        step(0, 0, 1, pb, 0);
        step(1, 0, 1, pc, 0);
        chk_reset_fields();
        step(0, 0, 0, idle, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            p = '{c: 3'($urandom), a: $urandom, w: $urandom, r: 5'($urandom)};
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                 1'($urandom), p, ($urandom_range(0, 2) != 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ex_mem_skid_stage.md
Name: ex_mem_skid_stage

Overview:
- Parametrised successor to the EX→MEM pipeline register.
- Carries the control bits, ALU result, store data and destination register from EX to MEM.
- Adds a valid/ready handshake, an optional one-entry skid buffer, a synchronous flush, and bubble insertion, so MEM back-pressure stalls EX without losing an instruction.
- Sits between the ALU and data-memory stages; the hazard unit reads its outputs for forwarding.

Parameters:
- DATA_W, 32, width of the ALU result and store data.
- REG_W, 5, width of the destination register index.
- CTRL_W, 3, control bits; bit0 RegWrite, bit1 MemtoReg, bit2 MemWrite.
- SKID_EN, 1; 1 = registered in_ready with a skid entry, 0 = single register with combinational in_ready.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  kill all held instructions this cycle.
- in_valid  in  1  EX presents an instruction.
- in_ready  out  1  stage can accept.
- in_ctrl  in  CTRL_W  control from EX.
- in_alu  in  DATA_W  ALU result.
- in_wdata  in  DATA_W  store data.
- in_wreg  in  REG_W  destination register.
- out_valid  out  1  MEM-side instruction valid.
- out_ready  in  1  MEM consumes this cycle.
- out_ctrl  out  CTRL_W  registered control.
- out_alu  out  DATA_W  registered ALU result.
- out_wdata  out  DATA_W  registered store data.
- out_wreg  out  REG_W  registered destination.
- occupancy  out  2  held entries (0..2).

Behaviour:
- Clocking: single clock domain. Reset is synchronous and active-high; rst is sampled only on the rising edge of clk.
- Reset: out_valid=0, out_ctrl=0, out_alu=0, out_wdata=0, out_wreg=0, skid entry invalid, occupancy=0, in_ready=1. A reset mid-stall discards both entries.
- Handshakes: accept = in_valid & in_ready; fire = out_valid & out_ready.
- Latency: an accepted instruction appears on out_* with out_valid=1 at the next rising edge when the main register is empty or firing.
- SKID_EN=1 states:
  - EMPTY: accept → ONE.
  - ONE: accept & fire → ONE (new data loaded into main). accept & !fire → TWO (data into skid). fire & !accept → EMPTY. Otherwise hold.
  - TWO: fire → ONE (skid moves to main). Otherwise hold.
  - in_ready is registered: in_ready = (state != TWO). There is no combinational path from out_ready to in_ready.
- SKID_EN=0:
  - in_ready = !out_valid | out_ready (combinational).
  - States are EMPTY/ONE only; the skid logic is not generated.
- Bubble rule: whenever out_valid=0, out_ctrl is held at 0, so MEM never writes on a bubble. out_alu/out_wdata/out_wreg keep their last values; they are don't-care when invalid.
- Hold rule: while out_valid=1 & !out_ready, all out_* stay stable; changing them is a protocol error.
- Flush (sync, priority over everything except rst):
  - Next state is EMPTY, out_valid=0, out_ctrl=0.
  - An instruction presented with accept in the flush cycle is dropped.
  - A fire in the flush cycle still counts as consumed by MEM.
- occupancy: EMPTY=0, ONE=1, TWO=2; updated on the same edge as the state.
- Widths: pure storage, no arithmetic, no truncation; all fields are stored at full parameter width.

Decomposition:
- Shared pipeline package holds:
  - control-bit index constants: CTRL_REGWRITE=0, CTRL_MEMTOREG=1, CTRL_MEMWRITE=2;
  - the payload width sum: CTRL_W+2*DATA_W+REG_W;
  - the state encoding: EMPTY/ONE/TWO.
- One sub-module, pipe_payload_reg: a width-parametrised enable/clear register. It is instantiated for the main entry and, when SKID_EN=1, the skid entry.

Test Plan:
- Reset and single pass: rst high 2 cycles, then accept ctrl=3'b001, alu=0x0000_00A5, wdata=0x1234_5678, wreg=5'd9 with out_ready=1. Required: out_valid=1 one cycle later with identical fields, then out_valid=0 and out_ctrl=0.
- Back-pressure with skid: out_ready=0, send A (alu=0x1), then B (alu=0x2). Required: occupancy=2, in_ready=0 on the next cycle, out_alu=0x1 stable. Then out_ready=1: A fires, then B fires, occupancy falls 2→1→0 with no loss or duplication.
- Streaming: in_valid=1 and out_ready=1 for 8 cycles, alu=0..7. Required: out_alu 0..7 on consecutive cycles, in_ready always 1, occupancy always 1 after the first.
- Flush while full: state TWO, assert flush with in_valid=1, alu=0xDEAD. Required: next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1, and 0xDEAD never appears.
- SKID_EN=0: out_valid=1, out_ready=0 → in_ready=0 in the same cycle. Raise out_ready → in_ready=1 in the same cycle, and a new accept then loads on the next edge.
- Reset mid-stall: occupancy=2, assert rst for 1 cycle. Required: all outputs equal the reset values listed in Behaviour and in_ready=1.
